// File: rtl/registro_botones_rep.sv
// N-channel button register with load/shift modes,
// press pulses, hold-to-repeat and sticky event flags.
module registro_botones_rep #(
  parameter int N             = 2,
  parameter int HOLD_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic [N-1:0] d_in,
  input  logic         sin_msb,
  input  logic         sin_lsb,
  input  logic         rep_en,
  input  logic [N-1:0] ack,
  output logic [N-1:0] q,
  output logic [N-1:0] pulse,
  output logic [N-1:0] pending
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_SHR  = 2'b10;
  localparam logic [1:0] M_SHL  = 2'b11;

  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  pulse_q, pulse_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [1:0]    st_q  [N];
  logic [1:0]    st_d  [N];
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Register next value selected by the operating mode.
  always_comb begin
    q_d = q_q;
    case (mode)
      M_HOLD:  q_d = q_q;
      M_LOAD:  q_d = d_in;
      M_SHR:   q_d = {sin_msb, q_q[N-1:1]};
      M_SHL:   q_d = {q_q[N-2:0], sin_lsb};
      default: q_d = q_q;
    endcase
  end

  // Per-channel press/hold/repeat FSM on the registered state.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      if (!q_q[i]) begin
        st_d[i]  = S_IDLE;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          S_IDLE: begin
            pulse_d[i] = 1'b1;
            st_d[i]    = S_DELAY;
            cnt_d[i]   = ONE_C;
          end
          S_DELAY: begin
            if (cnt_q[i] == HOLD_C) begin
              if (rep_en) begin
                pulse_d[i] = 1'b1;
                st_d[i]    = S_REPEAT;
                cnt_d[i]   = ONE_C;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_C;
            end
          end
          S_REPEAT: begin
            if (cnt_q[i] == REP_C) begin
              pulse_d[i] = rep_en;
              cnt_d[i]   = ONE_C;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_C;
            end
          end
          default: begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Sticky flags: a new pulse wins over a same-cycle ack.
  always_comb begin
    pending_d = (pending_q & ~ack) | pulse_q;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q       <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      q_q       <= q_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign q       = q_q;
  assign pulse   = pulse_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_registro_botones_rep.sv
// Bench for registro_botones_rep: vector table, spec
// sequences and a time-based random reference model.
module tb_registro_botones_rep;

  localparam int N = 4;
  localparam int H = 16;
  localparam int R = 4;

  localparam logic [1:0] MH  = 2'b00;
  localparam logic [1:0] ML  = 2'b01;
  localparam logic [1:0] MSR = 2'b10;
  localparam logic [1:0] MSL = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   mode = MH;
  logic [N-1:0] d_in = '0;
  logic         sin_msb = 1'b0;
  logic         sin_lsb = 1'b0;
  logic         rep_en = 1'b0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] q, pulse, pending;

  int checks = 0;
  int passes = 0;

  registro_botones_rep #(
    .N(N), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .d_in(d_in), .sin_msb(sin_msb), .sin_lsb(sin_lsb),
    .rep_en(rep_en), .ack(ack),
    .q(q), .pulse(pulse), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: absolute-time schedule per channel.
  logic [N-1:0] m_q, m_pulse, m_pend;
  logic [N-1:0] m_act, m_rep;
  int           m_nxt [N];
  int           cyc;
  logic [1:0]   pm;
  logic [N-1:0] pd, pack;
  logic         psm, psl, pen;

  task automatic model_reset();
    m_q = '0; m_pulse = '0; m_pend = '0;
    m_act = '0; m_rep = '0; cyc = 0;
    for (int i = 0; i < N; i++) m_nxt[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] np, npe, nq;
    npe = (m_pend & ~pack) | m_pulse;
    np = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_q[i]) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        np[i] = 1'b1;
        m_act[i] = 1'b1;
        m_rep[i] = 1'b0;
        m_nxt[i] = cyc + H;
      end else if (cyc == m_nxt[i]) begin
        if (pen) begin
          np[i] = 1'b1;
          m_rep[i] = 1'b1;
          m_nxt[i] = cyc + R;
        end else if (!m_rep[i]) begin
          m_nxt[i] = cyc + 1;
        end else begin
          m_nxt[i] = cyc + R;
        end
      end
    end
    case (pm)
      ML:  nq = pd;
      MSR: nq = {psm, m_q[N-1:1]};
      MSL: nq = {m_q[N-2:0], psl};
      default: nq = m_q;
    endcase
    m_q = nq; m_pulse = np; m_pend = npe;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // One clock; outputs sampled 1ns after the edge.
  task automatic step();
    pm = mode; pd = d_in; psm = sin_msb;
    psl = sin_lsb; pen = rep_en; pack = ack;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  task automatic apply_reset();
    mode = MH; d_in = '0; sin_msb = 0; sin_lsb = 0;
    ack = '0; rep_en = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] d;
    logic         sm;
    logic         sl;
    logic [N-1:0] ack;
    logic [N-1:0] eq;
    logic [N-1:0] ep;
    logic [N-1:0] epe;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(input logic [1:0] m,
                              input logic [N-1:0] d,
                              input logic sm, input logic sl,
                              input logic [N-1:0] a,
                              input logic [N-1:0] eq,
                              input logic [N-1:0] ep,
                              input logic [N-1:0] epe);
    vec_t v;
    v.mode = m; v.d = d; v.sm = sm; v.sl = sl;
    v.ack = a; v.eq = eq; v.ep = ep; v.epe = epe;
    return v;
  endfunction

  logic [N-1:0] exp_p;
  int           r;

  initial begin
    vt[0]  = mk(ML,  4'b0001, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    vt[1]  = mk(MH,  4'b0000, 0, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    vt[2]  = mk(MH,  4'b0000, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    vt[3]  = mk(MH,  4'b0000, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    vt[4]  = mk(ML,  4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    vt[5]  = mk(MH,  4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    vt[6]  = mk(MH,  4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    vt[7]  = mk(ML,  4'b0001, 0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    vt[8]  = mk(MSL, 4'b0000, 0, 0, 4'b0000, 4'b0010, 4'b0001, 4'b0000);
    vt[9]  = mk(MSL, 4'b0000, 0, 0, 4'b0000, 4'b0100, 4'b0010, 4'b0001);
    vt[10] = mk(MSL, 4'b0000, 0, 0, 4'b0000, 4'b1000, 4'b0100, 4'b0011);
    vt[11] = mk(MH,  4'b0000, 0, 0, 4'b1111, 4'b1000, 4'b1000, 4'b0100);
    vt[12] = mk(MSR, 4'b0000, 1, 0, 4'b1111, 4'b1100, 4'b0000, 4'b1000);
    vt[13] = mk(MSR, 4'b0000, 1, 0, 4'b1111, 4'b1110, 4'b0100, 4'b0000);
    vt[14] = mk(MSR, 4'b0000, 1, 0, 4'b1111, 4'b1111, 4'b0010, 4'b0100);
    vt[15] = mk(ML,  4'b0000, 0, 0, 4'b1111, 4'b0000, 4'b0001, 4'b0010);
    vt[16] = mk(MH,  4'b0000, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    vt[17] = mk(MH,  4'b0000, 0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    // Reset state.
    apply_reset();
    chk("reset q", 32'(q), 32'(0));
    chk("reset pulse", 32'(pulse), 32'(0));
    chk("reset pending", 32'(pending), 32'(0));

    // Load/release and shifting table.
    for (int i = 0; i < 18; i++) begin
      mode = vt[i].mode; d_in = vt[i].d;
      sin_msb = vt[i].sm; sin_lsb = vt[i].sl;
      ack = vt[i].ack;
      step();
      chk($sformatf("vec%0d q", i), 32'(q), 32'(vt[i].eq));
      chk($sformatf("vec%0d pulse", i), 32'(pulse), 32'(vt[i].ep));
      chk($sformatf("vec%0d pending", i),
          32'(pending), 32'(vt[i].epe));
    end

    // Auto-repeat with rep_en held high.
    apply_reset();
    mode = ML; d_in = 4'b0010; rep_en = 1'b1;
    step();
    mode = MH;
    for (int t = 1; t <= 40; t++) begin
      step();
      exp_p = ((t == 1) || (t >= 1 + H && (t - 1 - H) % R == 0))
              ? 4'b0010 : 4'b0000;
      chk($sformatf("autorep t%0d", t), 32'(pulse), 32'(exp_p));
    end

    // Repeat disabled, then enabled before cycle 31.
    apply_reset();
    mode = ML; d_in = 4'b0010; rep_en = 1'b0;
    step();
    mode = MH;
    for (int t = 1; t <= 40; t++) begin
      if (t == 31) rep_en = 1'b1;
      step();
      exp_p = (t == 1 || t == 31 || t == 35 || t == 39)
              ? 4'b0010 : 4'b0000;
      chk($sformatf("norep t%0d", t), 32'(pulse), 32'(exp_p));
    end

    // Ack colliding with a repeat pulse.
    apply_reset();
    mode = ML; d_in = 4'b0001; rep_en = 1'b1;
    step();
    mode = MH;
    for (int t = 1; t <= 21; t++) step();
    chk("collide pulse21", 32'(pulse), 32'(4'b0001));
    ack = 4'b0001;
    step();
    chk("collide pending22", 32'(pending[0]), 32'(1));
    step();
    chk("collide pending23", 32'(pending[0]), 32'(0));
    ack = '0;

    // Reset asserted mid-repeat while Load 1111 is held.
    apply_reset();
    mode = ML; d_in = 4'b1111; rep_en = 1'b1;
    for (int t = 0; t < 25; t++) step();
    chk("prereset q", 32'(q), 32'(4'b1111));
    #2;
    reset = 1'b1;
    #1;
    chk("midrst q", 32'(q), 32'(0));
    chk("midrst pulse", 32'(pulse), 32'(0));
    chk("midrst pending", 32'(pending), 32'(0));
    step();
    step();
    chk("inrst pulse", 32'(pulse), 32'(0));
    reset = 1'b0;
    step();
    chk("rel1 q", 32'(q), 32'(4'b1111));
    chk("rel1 pulse", 32'(pulse), 32'(0));
    step();
    chk("rel2 pulse", 32'(pulse), 32'(4'b1111));

    // Randomized traffic against the reference model.
    apply_reset();
    for (int t = 0; t < 800; t++) begin
      r = int'($urandom_range(0, 9));
      mode = (r < 6) ? MH : (r < 8) ? ML : (r == 8) ? MSR : MSL;
      d_in = N'($urandom);
      sin_msb = 1'($urandom);
      sin_lsb = 1'($urandom);
      if ($urandom_range(0, 19) == 0) rep_en = ~rep_en;
      ack = N'($urandom) & N'($urandom);
      step();
      chk($sformatf("rnd%0d q", t), 32'(q), 32'(m_q));
      chk($sformatf("rnd%0d pulse", t), 32'(pulse), 32'(m_pulse));
      chk($sformatf("rnd%0d pending", t),
          32'(pending), 32'(m_pend));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
